// File: rtl/pixel_packet_scheduler.sv
// Packs pixels into LINES-wide packets, queues them in a FIFO and hands them to an SPI sender.
// Optional feature: define PKT_DROP_COUNT_EN to add a saturating 16-bit dropped-packet counter.
module pixel_packet_scheduler #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINES       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int H_LAST      = 639,
  parameter int V_LAST      = 359
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0]       pixel_data_in,
  input  logic [9:0]                   pixel_hcount_in,
  input  logic [8:0]                   pixel_vcount_in,
  input  logic                         frame_start_in,
  input  logic                         spi_busy_in,
  output logic [LINES*PIXEL_WIDTH-1:0] packet_data_out,
  output logic                         packet_trigger_out,
  output logic                         packet_last_out,
  output logic                         overflow_out
`ifdef PKT_DROP_COUNT_EN
  ,
  output logic [15:0]                  drop_count_out
`endif
);

  localparam int PKT_W  = LINES * PIXEL_WIDTH;
  localparam int LANE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ISSUE      = 2'd1;
  localparam logic [1:0] ST_WAIT_START = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [LANE_W-1:0]      r_lane_idx;
  logic [PIXEL_WIDTH-1:0] r_lanes [LINES];
  logic [LANE_W-1:0]      w_idx;
  logic                   w_final;
  logic                   w_close;
  logic [PKT_W-1:0]       w_pkt;

  // A frame start in the same cycle as a pixel discards first, so the pixel lands in lane 0.
  always_comb begin
    w_idx   = frame_start_in ? '0 : r_lane_idx;
    w_final = (pixel_hcount_in == 10'(H_LAST)) && (pixel_vcount_in == 9'(V_LAST));
    w_close = pixel_valid_in && (w_final || (w_idx == LANE_W'(LINES - 1)));
    w_pkt   = '0;
    for (int j = 0; j < LINES; j++) begin
      if (LANE_W'(j) == w_idx)
        w_pkt[j*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data_in;
      else if (LANE_W'(j) < w_idx)
        w_pkt[j*PIXEL_WIDTH +: PIXEL_WIDTH] = r_lanes[j];
    end
  end

  always_ff @(posedge clk_in) begin
    if (pixel_valid_in) r_lanes[w_idx] <= pixel_data_in;
  end

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n)            r_lane_idx <= '0;
    else if (w_close)        r_lane_idx <= '0;
    else if (pixel_valid_in) r_lane_idx <= w_idx + 1'b1;
    else if (frame_start_in) r_lane_idx <= '0;
  end

  logic [PKT_W:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [PKT_W:0]   w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [1:0]       r_state;
  logic [1:0]       r_wait_cnt;
  logic             r_trigger;
  logic [PKT_W-1:0] r_pkt_data;
  logic             r_pkt_last;
  logic             r_overflow;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
  always_comb begin
    w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
              (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    w_pop   = (r_state == ST_IDLE) && !w_empty && !spi_busy_in;
    w_push  = w_close && (!w_full || w_pop);
    w_drop  = w_close && w_full && !w_pop;
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {w_final, w_pkt};
  end

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // The head is captured on the pop, so the output holds steady until the next issue.
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pkt_data <= '0;
      r_pkt_last <= 1'b0;
    end else if (w_pop) begin
      {r_pkt_last, r_pkt_data} <= w_head;
    end
  end

  // A sender that never raises busy is treated as done after four waiting cycles.
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_trigger  <= 1'b0;
    end else begin
      r_trigger <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state   <= ST_ISSUE;
            r_trigger <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state    <= ST_WAIT_START;
          r_wait_cnt <= '0;
        end
        ST_WAIT_START: begin
          if (spi_busy_in)              r_state    <= ST_WAIT_DONE;
          else if (r_wait_cnt == 2'd3)  r_state    <= ST_IDLE;
          else                          r_wait_cnt <= r_wait_cnt + 2'd1;
        end
        ST_WAIT_DONE: begin
          if (!spi_busy_in) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign packet_data_out    = r_pkt_data;
  assign packet_trigger_out = r_trigger;
  assign packet_last_out    = r_pkt_last;
  assign overflow_out       = r_overflow;

`ifdef PKT_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n)    r_drop_count <= '0;
    else if (w_drop) r_drop_count <= sat_inc16(r_drop_count);
  end

  assign drop_count_out = r_drop_count;
`endif

endmodule

// File: tb/tb_pixel_packet_scheduler.sv
// Directed bench for pixel_packet_scheduler: table of single packets plus multi-cycle sequences.
module tb_pixel_packet_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        pixel_valid_in = 1'b0;
  logic [7:0]  pixel_data_in = '0;
  logic [9:0]  pixel_hcount_in = '0;
  logic [8:0]  pixel_vcount_in = '0;
  logic        frame_start_in = 1'b0;
  logic        spi_busy_in = 1'b0;
  logic [31:0] packet_data_out;
  logic        packet_trigger_out;
  logic        packet_last_out;
  logic        overflow_out;
`ifdef PKT_DROP_COUNT_EN
  logic [15:0] drop_count_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic prev_trig = 1'b0;
  logic [32:0] trig_q [$];
  int          trig_cyc_q [$];

  pixel_packet_scheduler #(
    .PIXEL_WIDTH(8), .LINES(4), .FIFO_DEPTH(8), .H_LAST(639), .V_LAST(359)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .pixel_valid_in     (pixel_valid_in),
    .pixel_data_in      (pixel_data_in),
    .pixel_hcount_in    (pixel_hcount_in),
    .pixel_vcount_in    (pixel_vcount_in),
    .frame_start_in     (frame_start_in),
    .spi_busy_in        (spi_busy_in),
    .packet_data_out    (packet_data_out),
    .packet_trigger_out (packet_trigger_out),
    .packet_last_out    (packet_last_out),
    .overflow_out       (overflow_out)
`ifdef PKT_DROP_COUNT_EN
    ,
    .drop_count_out     (drop_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (packet_trigger_out === 1'b1) begin
      check("trig_single_cycle", {63'd0, prev_trig}, 64'd0);
      trig_q.push_back({packet_last_out, packet_data_out});
      trig_cyc_q.push_back(cyc);
    end
    prev_trig = packet_trigger_out;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pix(input logic [7:0] d, input logic fin, input logic fs);
    pixel_valid_in  = 1'b1;
    pixel_data_in   = d;
    frame_start_in  = fs;
    pixel_hcount_in = fin ? 10'd639 : 10'd100;
    pixel_vcount_in = fin ? 9'd359 : 9'd10;
    @(negedge clk_in);
    pixel_valid_in  = 1'b0;
    frame_start_in  = 1'b0;
    pixel_hcount_in = '0;
    pixel_vcount_in = '0;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic push_pkt(input logic [7:0] b);
    for (int j = 0; j < 4; j++) pix(b + 8'(j), 1'b0, 1'b0);
  endtask

  task automatic wait_trig(input int budget, input string name);
    int k = 0;
    while (packet_trigger_out !== 1'b1 && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    check(name, {63'd0, packet_trigger_out}, 64'd1);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick(3);
    rst_in = 1'b1;
    tick(4);
    trig_q.delete();
    trig_cyc_q.delete();
  endtask

  typedef struct {
    int          n;
    logic [31:0] px;
    logic        fin;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 1'b0};
    vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 1'b1};
    vecs[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 1'b1};
    vecs[3] = '{4, 32'h04030201, 1'b1, 32'h04030201, 1'b1};
    vecs[4] = '{3, 32'h00C2C1C0, 1'b1, 32'h00C2C1C0, 1'b1};

    #2 rst_in = 1'b0;
    tick(3);
    check("rst_trigger", {63'd0, packet_trigger_out}, 64'd0);
    check("rst_data",    {32'd0, packet_data_out},    64'd0);
    check("rst_last",    {63'd0, packet_last_out},    64'd0);
    check("rst_overflow",{63'd0, overflow_out},       64'd0);
    rst_in = 1'b1;
    tick(4);
    trig_q.delete();
    trig_cyc_q.delete();

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++)
        pix(vecs[i].px[j*8 +: 8], vecs[i].fin && (j == vecs[i].n - 1), 1'b0);
      check("tbl_trig_early", {63'd0, packet_trigger_out}, 64'd0);
      tick(1);
      check("tbl_trig",  {63'd0, packet_trigger_out}, 64'd1);
      check("tbl_data",  {32'd0, packet_data_out},    {32'd0, vecs[i].exp_data});
      check("tbl_last",  {63'd0, packet_last_out},    {63'd0, vecs[i].exp_last});
      tick(8);
      check("tbl_hold",  {32'd0, packet_data_out},    {32'd0, vecs[i].exp_data});
    end
    check("tbl_count", 64'(trig_q.size()), 64'd5);

    // Sender never raises busy: second packet follows after the 4-cycle timeout.
    c0 = trig_q.size();
    push_pkt(8'h10);
    push_pkt(8'h20);
    tick(30);
    check("to_count", 64'(trig_q.size()), 64'(c0 + 2));
    check("to_gap",   64'(trig_cyc_q[c0+1] - trig_cyc_q[c0]), 64'd6);
    check("to_first", {31'd0, trig_q[c0]},   {31'd0, 1'b0, mk(8'h10)});
    check("to_second",{31'd0, trig_q[c0+1]}, {31'd0, 1'b0, mk(8'h20)});

    // Busy handshake: next packet waits until busy falls.
    spi_busy_in = 1'b1;
    c0 = trig_q.size();
    push_pkt(8'h30);
    push_pkt(8'h38);
    tick(2);
    check("hs_blocked", 64'(trig_q.size()), 64'(c0));
    spi_busy_in = 1'b0;
    wait_trig(10, "hs_first_trig");
    check("hs_first_data", {32'd0, packet_data_out}, {32'd0, mk(8'h30)});
    spi_busy_in = 1'b1;
    tick(10);
    check("hs_held", 64'(trig_q.size()), 64'(c0 + 1));
    spi_busy_in = 1'b0;
    tick(1);
    check("hs_after_idle", {63'd0, packet_trigger_out}, 64'd0);
    tick(1);
    check("hs_second_trig", {63'd0, packet_trigger_out}, 64'd1);
    check("hs_second_data", {32'd0, packet_data_out}, {32'd0, mk(8'h38)});
    tick(12);

    // Frame start discards a partial packet (alone, then together with a pixel).
    c0 = trig_q.size();
    pix(8'hE0, 1'b0, 1'b0); pix(8'hE1, 1'b0, 1'b0); pix(8'hE2, 1'b0, 1'b0);
    frame_start_in = 1'b1;
    tick(1);
    frame_start_in = 1'b0;
    push_pkt(8'h50);
    wait_trig(10, "fs_trig");
    check("fs_data", {32'd0, packet_data_out}, {32'd0, mk(8'h50)});
    tick(12);
    pix(8'hE4, 1'b0, 1'b0); pix(8'hE5, 1'b0, 1'b0); pix(8'hE6, 1'b0, 1'b0);
    pix(8'h60, 1'b0, 1'b1); pix(8'h61, 1'b0, 1'b0); pix(8'h62, 1'b0, 1'b0); pix(8'h63, 1'b0, 1'b0);
    wait_trig(10, "fs_pix_trig");
    check("fs_pix_data", {32'd0, packet_data_out}, {32'd0, mk(8'h60)});
    tick(12);
    check("fs_count", 64'(trig_q.size()), 64'(c0 + 2));

    // Full FIFO with simultaneous push and pop: nothing dropped.
    do_reset();
    spi_busy_in = 1'b1;
    for (int p = 0; p < 8; p++) push_pkt(8'h80 + 8'(4*p));
    pix(8'hA0, 1'b0, 1'b0); pix(8'hA1, 1'b0, 1'b0); pix(8'hA2, 1'b0, 1'b0);
    spi_busy_in = 1'b0;
    pix(8'hA3, 1'b0, 1'b0);
    check("pp_overflow", {63'd0, overflow_out}, 64'd0);
    for (int p = 0; p < 9; p++) begin
      wait_trig(40, "pp_trig");
      check("pp_data", {32'd0, packet_data_out}, {32'd0, mk(8'h80 + 8'(4*p))});
      tick(1);
    end
    tick(12);
    check("pp_count", 64'(trig_q.size()), 64'd9);

    // Overflow: ninth packet into a full FIFO is dropped.
    do_reset();
    spi_busy_in = 1'b1;
    for (int p = 0; p < 8; p++) push_pkt(8'h40 + 8'(4*p));
    check("ovf_not_yet", {63'd0, overflow_out}, 64'd0);
    push_pkt(8'hF0);
    check("ovf_set", {63'd0, overflow_out}, 64'd1);
`ifdef PKT_DROP_COUNT_EN
    check("ovf_drop_count", {48'd0, drop_count_out}, 64'd1);
`endif
    spi_busy_in = 1'b0;
    for (int p = 0; p < 8; p++) begin
      wait_trig(40, "ovf_trig");
      check("ovf_data", {32'd0, packet_data_out}, {32'd0, mk(8'h40 + 8'(4*p))});
      tick(1);
    end
    tick(12);
    check("ovf_count", 64'(trig_q.size()), 64'd8);
    check("ovf_sticky", {63'd0, overflow_out}, 64'd1);

    // Reset while waiting for the sender with packets queued.
    spi_busy_in = 1'b1;
    push_pkt(8'hC0);
    spi_busy_in = 1'b0;
    wait_trig(10, "rm_first_trig");
    spi_busy_in = 1'b1;
    push_pkt(8'hC4); push_pkt(8'hC8); push_pkt(8'hCC);
    pix(8'hD0, 1'b0, 1'b0); pix(8'hD1, 1'b0, 1'b0);
    rst_in = 1'b0;
    #1;
    check("rm_trigger",  {63'd0, packet_trigger_out}, 64'd0);
    check("rm_data",     {32'd0, packet_data_out},    64'd0);
    check("rm_last",     {63'd0, packet_last_out},    64'd0);
    check("rm_overflow", {63'd0, overflow_out},       64'd0);
`ifdef PKT_DROP_COUNT_EN
    check("rm_drop_count", {48'd0, drop_count_out}, 64'd0);
`endif
    @(negedge clk_in);
    tick(2);
    rst_in = 1'b1;
    spi_busy_in = 1'b0;
    c0 = trig_q.size();
    tick(20);
    check("rm_no_trig", 64'(trig_q.size()), 64'(c0));
    push_pkt(8'h0A);
    wait_trig(10, "rm_new_trig");
    check("rm_new_data", {32'd0, packet_data_out}, {32'd0, mk(8'h0A)});
    check("rm_new_last", {63'd0, packet_last_out}, 64'd0);
    tick(12);
    check("rm_count", 64'(trig_q.size()), 64'(c0 + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
